// File: rtl/seg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    BLANK,
    SHOW
  } scan_state_e;

  function automatic int idx_width(input int num_digits);
    return (num_digits <= 1) ? 1 : $clog2(num_digits);
  endfunction

  function automatic int cnt_width(input int refresh_div, input int blank_cycles);
    int longest;
    longest = (refresh_div > blank_cycles) ? refresh_div : blank_cycles;
    return (longest <= 1) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake between the hex-value producer and the scan controller.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
) ();

  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;
  logic [NUM_DIGITS-1:0]   load_mask;
  logic [NUM_DIGITS-1:0]   load_dp;

  modport master (
    output load_valid,
    output load_data,
    output load_mask,
    output load_dp,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_mask,
    input  load_dp,
    output load_ready
  );

endinterface

// File: rtl/seven_segment.sv
// Hex nibble to active-high segment pattern, bit0 = a ... bit6 = g.
module seven_segment (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b0000000;
    case (hex_i)
      4'h0: seg_o = 7'b0111111;
      4'h1: seg_o = 7'b0000110;
      4'h2: seg_o = 7'b1011011;
      4'h3: seg_o = 7'b1001111;
      4'h4: seg_o = 7'b1100110;
      4'h5: seg_o = 7'b1101101;
      4'h6: seg_o = 7'b1111101;
      4'h7: seg_o = 7'b0000111;
      4'h8: seg_o = 7'b1111111;
      4'h9: seg_o = 7'b1101111;
      4'hA: seg_o = 7'b1110111;
      4'hB: seg_o = 7'b1111100;
      4'hC: seg_o = 7'b0111001;
      4'hD: seg_o = 7'b1011110;
      4'hE: seg_o = 7'b1111001;
      4'hF: seg_o = 7'b1110001;
      default: seg_o = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS common-anode digits with a blanking gap
// between digits and a one-entry load buffer that only takes effect at frame boundaries.
module seven_seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_seg_scan_ctrl_if.slave  load_if,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int CNT_W = cnt_width(REFRESH_DIV, BLANK_CYCLES);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             boundary;

  logic [4*NUM_DIGITS-1:0] act_data_q, pend_data_q;
  logic [NUM_DIGITS-1:0]   act_mask_q, pend_mask_q;
  logic [NUM_DIGITS-1:0]   act_dp_q,   pend_dp_q;
  logic                    pend_vld_q;

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  frame_done_q;

  logic       accept;
  logic       lit;
  logic [3:0] nibble;
  logic [6:0] dec_seg;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + 1'b1;
    boundary = 1'b0;
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  assign accept = load_if.load_valid && !pend_vld_q;

  // Outputs are computed from the next state so they switch on the same edge as the FSM.
  assign nibble = act_data_q[{idx_d, 2'b00} +: 4];
  assign lit    = (state_d == SHOW) && act_mask_q[idx_d];

  seven_segment u_decoder (
    .hex_i (nibble),
    .seg_o (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      act_data_q   <= '0;
      act_mask_q   <= '0;
      act_dp_q     <= '0;
      pend_data_q  <= '0;
      pend_mask_q  <= '0;
      pend_dp_q    <= '0;
      pend_vld_q   <= 1'b0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;

      // A word accepted on the boundary cycle lands in pending, never straight in active.
      if (boundary && pend_vld_q) begin
        act_data_q <= pend_data_q;
        act_mask_q <= pend_mask_q;
        act_dp_q   <= pend_dp_q;
      end
      if (accept) begin
        pend_data_q <= load_if.load_data;
        pend_mask_q <= load_if.load_mask;
        pend_dp_q   <= load_if.load_dp;
        pend_vld_q  <= 1'b1;
      end else if (boundary) begin
        pend_vld_q  <= 1'b0;
      end

      seg_q        <= lit ? dec_seg : SEG_BLANK;
      dp_q         <= lit && act_dp_q[idx_d];
      an_q         <= lit ? (NUM_DIGITS'(1) << idx_d) : '0;
      frame_done_q <= (state_d == SHOW) && (idx_d == IDX_LAST) && (cnt_d == SHOW_LAST);
    end
  end

  assign load_if.load_ready = !pend_vld_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench: a cycle-time reference model predicts every output window,
// a negedge monitor pops and compares.
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int SLOT  = BC + RD;
  localparam int FRAME = ND * SLOT;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
    logic       rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] seg;
  logic dp;
  logic [ND-1:0] an;
  logic frameDone;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) loadIf ();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_if    (loadIf.slave),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frameDone)
  );

  exp_t expQ[$];
  exp_t monExp;
  int testsRun = 0;
  int testsFailed = 0;
  int cycleCount = 0;

  // Reference model: time since reset plus the two loaded words.
  int mT = 0;
  logic [15:0] actData = '0, pendData = '0;
  logic [3:0]  actMask = '0, pendMask = '0;
  logic [3:0]  actDp = '0, pendDp = '0;
  bit pendVld = 1'b0;

  function automatic exp_t expectedNow();
    exp_t e;
    int f, d, p;
    bit lit;
    f = mT % FRAME;
    d = f / SLOT;
    p = f % SLOT;
    lit = (p >= BC) && actMask[d];
    e.seg = lit ? SEG_LUT[actData[d*4 +: 4]] : 7'd0;
    e.dp  = lit && actDp[d];
    e.an  = lit ? 4'(1 << d) : 4'd0;
    e.fd  = (f == FRAME - 1);
    e.rdy = !pendVld;
    return e;
  endfunction

  task automatic modelEdge(input bit rstnIn, input bit valid, input logic [15:0] data,
                           input logic [3:0] mask, input logic [3:0] dpIn);
    bit accept;
    if (!rstnIn) begin
      mT = 0;
      actData = '0; actMask = '0; actDp = '0;
      pendVld = 1'b0;
    end else begin
      accept = valid && !pendVld;
      if ((mT % FRAME == FRAME - 1) && pendVld) begin
        actData = pendData; actMask = pendMask; actDp = pendDp;
        pendVld = 1'b0;
      end
      if (accept) begin
        pendData = data; pendMask = mask; pendDp = dpIn;
        pendVld = 1'b1;
      end
      mT++;
    end
  endtask

  task automatic applyStimulus(input bit rstnIn, input bit valid, input logic [15:0] data,
                               input logic [3:0] mask, input logic [3:0] dpIn);
    expQ.push_back(expectedNow());
    rst_n = rstnIn;
    loadIf.load_valid = valid;
    loadIf.load_data  = data;
    loadIf.load_mask  = mask;
    loadIf.load_dp    = dpIn;
    @(posedge clk);
    modelEdge(rstnIn, valid, data, mask, dpIn);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic runUntil(input int targetF);
    for (int i = 0; i < 4 * FRAME; i++) begin
      if ((mT % FRAME == targetF) && !pendVld) return;
      idle(1);
    end
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL runUntil: frame position %0d with empty pending not reached", targetF);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycleCount, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      checkOutput("seg", 32'(seg), 32'(monExp.seg));
      checkOutput("dp", 32'(dp), 32'(monExp.dp));
      checkOutput("an", 32'(an), 32'(monExp.an));
      checkOutput("frame_done", 32'(frameDone), 32'(monExp.fd));
      checkOutput("load_ready", 32'(loadIf.load_ready), 32'(monExp.rdy));
      cycleCount++;
    end
  end

  initial begin
    bit willAccept;
    bit accepted;
    loadIf.load_valid = 1'b0;
    loadIf.load_data  = '0;
    loadIf.load_mask  = '0;
    loadIf.load_dp    = '0;
    @(posedge clk);
    modelEdge(1'b0, 1'b0, '0, '0, '0);
    #1;

    // Reset held, then a full dark frame.
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    idle(FRAME + 5);

    // Basic load.
    runUntil(20);
    applyStimulus(1'b1, 1'b1, 16'h1234, 4'b1111, 4'b0000);
    idle(2 * FRAME);

    // Back-to-back: A accepted, B held until the cycle after the boundary.
    runUntil(5);
    applyStimulus(1'b1, 1'b1, 16'h0000, 4'b1111, 4'b0000);
    accepted = 1'b0;
    for (int i = 0; i < 2 * FRAME && !accepted; i++) begin
      willAccept = !pendVld;
      applyStimulus(1'b1, 1'b1, 16'hFFFF, 4'b1111, 4'b0000);
      accepted = willAccept;
    end
    idle(2 * FRAME);

    // Mask and decimal point.
    runUntil(10);
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 4'b0101, 4'b0001);
    idle(2 * FRAME);

    // Load exactly on the boundary cycle.
    runUntil(FRAME - 1);
    applyStimulus(1'b1, 1'b1, 16'hABCD, 4'b1011, 4'b1010);
    idle(2 * FRAME + 3);

    // Reset during digit 2 SHOW while a word is pending.
    runUntil(0);
    applyStimulus(1'b1, 1'b1, 16'h5678, 4'b1111, 4'b1111);
    idle(24);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    idle(FRAME + 5);

    // Random traffic with occasional resets.
    for (int i = 0; i < 900; i++) begin
      applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) == 0),
                    16'($urandom), 4'($urandom), 4'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard drain: got %0d entries left, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It shares a single `seven_segment` hex decoder across `NUM_DIGITS` digits. It accepts a new display word through a valid/ready handshake and buffers it so updates apply only at frame boundaries (no tearing). It also inserts a blanking gap between digits to suppress ghosting, and sits between the system logic that produces hex values and the board display pins.

## Interface
- `NUM_DIGITS`, 4, digits scanned per frame (1..8)
- `REFRESH_DIV`, 50000, SHOW cycles per digit slot (>=1)
- `BLANK_CYCLES`, 16, BLANK cycles preceding each SHOW (>=1)
- `clk`  in  1  single clock; everything is synchronous to its rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `load_valid`  in  1  new display word offered
- `load_ready`  out  1  pending buffer empty; a transfer occurs when `load_valid && load_ready`
- `load_data`  in  4*NUM_DIGITS  hex nibbles; `[3:0]` = digit 0
- `load_mask`  in  NUM_DIGITS  per-digit enable, captured with `load_data`
- `load_dp`  in  NUM_DIGITS  per-digit decimal point, captured with `load_data`
- `seg`  out  7  active-high segments; bit0=a … bit6=g, decoder encoding
- `dp`  out  1  active-high decimal point
- `an`  out  NUM_DIGITS  one-hot active-high digit select; all zero when blanked
- `frame_done`  out  1  one-cycle pulse on the last cycle of each frame

## Operation
- Two register sets:
  - **active**: data, mask and dp currently displayed.
  - **pending**: data, mask and dp plus `pend_vld`, a one-entry buffer.
- Handshake: `load_ready = !pend_vld` (registered). On accept, the word is written to pending and `pend_vld` is set.
- FSM states and transitions:
  - BLANK -> SHOW after `BLANK_CYCLES` cycles.
  - SHOW -> BLANK after `REFRESH_DIV` cycles, incrementing the digit index.
  - At the end of SHOW for digit `NUM_DIGITS-1` the index wraps to 0 and the frame ends.
- Frame boundary (the edge ending the last SHOW cycle):
  - If `pend_vld`, pending is copied to active and `pend_vld` clears.
  - `load_ready` is high from the next cycle.
  - A load accepted on the boundary cycle itself goes to pending, not active.
- BLANK: `an`=0, `seg`=0, `dp`=0.
- SHOW digit i:
  - If `mask[i]`: `an`=1<<i, `seg`=decode(active nibble i), `dp`=active dp[i].
  - If `!mask[i]`: outputs stay 0, but the slot is still consumed, so the frame period is constant.
- Width/arithmetic:
  - Slot counter width is clog2(max(REFRESH_DIV, BLANK_CYCLES)).
  - Digit index width is clog2(NUM_DIGITS), min 1.
  - Index wrap is explicit compare-to-(NUM_DIGITS-1), not power-of-two overflow.
- Reset (asserted at any point, including mid-frame or with pending valid):
  - State BLANK, index 0, counter 0.
  - Active data, mask and dp = 0, so the display is dark until the first load.
  - Pending is dropped and `pend_vld`=0.
  - Outputs: `seg`=0, `dp`=0, `an`=0, `frame_done`=0, `load_ready`=1.

## Timing
- All outputs are registered and change on the same edge as the state transition; there is no combinational path from inputs to outputs.
- Slot length: `BLANK_CYCLES+REFRESH_DIV` cycles. Frame length: `NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV)` cycles.
- Load-to-display latency:
  - Minimum: 1 cycle to the frame boundary.
  - Maximum: one full frame plus `BLANK_CYCLES+1` before the first lit digit.
- After reset release, the first frame starts immediately with BLANK of digit 0.
- If `load_valid` is held while `load_ready`=0, the word is accepted in the first cycle `load_ready`=1, i.e. the cycle after the boundary.

## Structure
- Package `seg_pkg`:
  - `SEG_BLANK` = 7'b0000000.
  - Scan state enum {BLANK, SHOW}.
  - Width helper for the digit index.
- Sub-module: instantiate the existing `seven_segment` decoder once, driven by a mux of the active nibble at the current index. Its output is registered in this block.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 (slot = 10 cycles, frame = 40 cycles).

- **Reset:** hold `rst_n`=0 for 3 cycles -> `an`=0, `seg`=0, `dp`=0, `frame_done`=0, `load_ready`=1; display dark for the whole first frame; `frame_done` at cycle 40.
- **Basic load:** load `0x1234`, mask `1111`, dp `0000` before a boundary -> next frame shows:
  - `an`=0001 with `seg`=1100110 for cycles 3–10 of the frame;
  - digit 3 with `seg`=0000110.
- **Back-to-back loads:** load A=`0x0000`, then B=`0xFFFF` in the same frame -> `load_ready` is low after A; B is accepted the cycle after the boundary; A is shown for exactly one frame, then B (`seg`=1110001).
- **Mask and dp:** mask `0101`, data `0xFFFF`, dp `0001` -> `an` pulses only 0001 and 0100; `dp`=1 only in digit 0 SHOW; `frame_done` period stays 40.
- **Mid-frame reset:** assert reset during digit 2 SHOW with `pend_vld`=1 -> next cycle all outputs 0, `load_ready`=1; pending is never displayed.
- **Load on boundary cycle:** `load_valid` high on the boundary cycle with pending empty -> the word goes to pending, not active, and is displayed from the following frame.
